// File: rtl/mem_arbiter.sv
// Purpose : two-requester round-robin arbiter/sequencer for a single synchronous memory port.
// Latency : legal command acks 2 cycles after the accepting edge, illegal command (rd==wr) acks 1 cycle after.
// Backpress: requesters hold reqN until ackN; a loser simply waits, at most one transaction per 4 cycles.
//
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   req/rd/wr/addr/wdata{0,1}     - requester command (held until ack)
//   ack/err/rdata{0,1}            - completion pulse, illegal-command flag, read data (held until next ack)
//   mem_read/mem_write/mem_addr/mem_data_in/mem_data_out - memory port
//
// Build option: define MEM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties),
// otherwise round-robin with a priority pointer.

module mem_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              rd0,
   input  logic              wr0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              req1,
   input  logic              rd1,
   input  logic              wr1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              err0,
   output logic [DATA_W-1:0] rdata0,
   output logic              ack1,
   output logic              err1,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t state;
   logic   gnt;      // id of the requester owning the current transaction
   logic   lat_rd;   // current transaction is a legal read
   logic   lat_err;  // current transaction is illegal
`ifndef MEM_ARB_FIXED_PRIO_EN
   logic   ptr;      // preferred requester on a tie
`endif

   // A requester still holding req in the cycle its ack is visible must not be re-granted.
   logic req0_eff, req1_eff, any_req, win;
   logic sel_rd, sel_wr, sel_illegal;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   assign req0_eff = req0 & ~ack0;
   assign req1_eff = req1 & ~ack1;
   assign any_req  = req0_eff | req1_eff;

   always_comb begin
      win = 1'b0;
`ifdef MEM_ARB_FIXED_PRIO_EN
      win = ~req0_eff;
`else
      if (req0_eff && req1_eff)
         win = ptr;
      else
         win = req1_eff;
`endif
   end

   assign sel_rd      = win ? rd1    : rd0;
   assign sel_wr      = win ? wr1    : wr0;
   assign sel_addr    = win ? addr1  : addr0;
   assign sel_wdata   = win ? wdata1 : wdata0;
   assign sel_illegal = (sel_rd == sel_wr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         gnt         <= 1'b0;
         lat_rd      <= 1'b0;
         lat_err     <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
         ptr         <= 1'b0;
`endif
         ack0        <= 1'b0;
         err0        <= 1'b0;
         rdata0      <= '0;
         ack1        <= 1'b0;
         err1        <= 1'b0;
         rdata1      <= '0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         mem_addr    <= '0;
         mem_data_in <= '0;
      end else begin
         // Pulses and strobes default low; each is set for exactly one cycle below.
         ack0      <= 1'b0;
         err0      <= 1'b0;
         ack1      <= 1'b0;
         err1      <= 1'b0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;

         case (state)
            IDLE: begin
               if (any_req) begin
                  gnt     <= win;
                  lat_err <= sel_illegal;
                  lat_rd  <= sel_rd & ~sel_wr;
`ifndef MEM_ARB_FIXED_PRIO_EN
                  ptr     <= ~win;
`endif
                  if (sel_illegal) begin
                     // No memory cycle for an illegal command.
                     state <= RESP;
                  end else begin
                     mem_read    <= sel_rd;
                     mem_write   <= sel_wr;
                     mem_addr    <= sel_addr;
                     mem_data_in <= sel_wdata;
                     state       <= ACCESS;
                  end
               end
            end

            ACCESS: begin
               // Memory samples the strobes on this edge; read data is valid next cycle.
               state <= RESP;
            end

            RESP: begin
               if (gnt) begin
                  ack1 <= 1'b1;
                  err1 <= lat_err;
                  if (lat_rd)
                     rdata1 <= mem_data_out;
               end else begin
                  ack0 <= 1'b1;
                  err0 <= lat_err;
                  if (lat_rd)
                     rdata0 <= mem_data_out;
               end
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : directed, table-driven bench for mem_arbiter with a behavioural 32x8 memory.
// Latency : checks ack timing per transaction (3 edges legal, 2 edges illegal from req assertion).
// Backpress: requesters hold req until ack, as the arbiter expects.

module tb_mem_arbiter;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              req0, rd0, wr0, req1, rd1, wr1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              ack0, err0, ack1, err1;
   logic [DATA_W-1:0] rdata0, rdata1;
   logic              mem_read, mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data_in;
   logic [DATA_W-1:0] mem_data_out = '0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .rd0(rd0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .rd1(rd1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
      .ack0(ack0), .err0(err0), .rdata0(rdata0),
      .ack1(ack1), .err1(err1), .rdata1(rdata1),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
   );

   // Synchronous memory: write and registered read on the strobe edge.
   logic [DATA_W-1:0] mem [32];
   initial for (int i = 0; i < 32; i++) mem[i] = '0;
   always @(posedge clk) begin
      if (mem_write) mem[mem_addr] <= mem_data_in;
      if (mem_read)  mem_data_out  <= mem[mem_addr];
   end

   // Strobe protocol monitor: never both, never wider than one cycle.
   int   strobe_bad = 0;
   logic prev_rd = 1'b0, prev_wr = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         prev_rd = 1'b0;
         prev_wr = 1'b0;
      end else begin
         if (mem_read && mem_write) strobe_bad++;
         if ((mem_read && prev_rd) || (mem_write && prev_wr)) strobe_bad++;
         prev_rd = mem_read;
         prev_wr = mem_write;
      end
   end

   int checks = 0;
   int fails  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input int rq, input logic r, input logic w,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic q);
      if (rq == 0) begin
         req0 = q; rd0 = r; wr0 = w; addr0 = a; wdata0 = d;
      end else begin
         req1 = q; rd1 = r; wr1 = w; addr1 = a; wdata1 = d;
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ack0"},  ack0, 0);
      check({tag, "_ack1"},  ack1, 0);
      check({tag, "_err0"},  err0, 0);
      check({tag, "_err1"},  err1, 0);
      check({tag, "_rdata0"}, rdata0, 0);
      check({tag, "_rdata1"}, rdata1, 0);
      check({tag, "_mem_read"}, mem_read, 0);
      check({tag, "_mem_write"}, mem_write, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_mem_data_in"}, mem_data_in, 0);
   endtask

   typedef struct {
      int                rq;
      logic              rd;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic              exp_err;
      logic [DATA_W-1:0] exp_rdata;
      int                exp_edges;
   } vec_t;

   // One transaction on an idle arbiter, starting and ending on a negedge.
   task automatic do_txn(input vec_t v, input string tag);
      int                edges = 0;
      int                nrd = 0;
      int                nwr = 0;
      logic              got = 1'b0;
      logic              e = 1'b0;
      logic              aok = 1'b1;
      logic [DATA_W-1:0] rdv = '0;
      drive(v.rq, v.rd, v.wr, v.addr, v.wdata, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (mem_read)  nrd++;
         if (mem_write) nwr++;
         if (mem_write && (mem_addr !== v.addr || mem_data_in !== v.wdata)) aok = 1'b0;
         if (mem_read && mem_addr !== v.addr) aok = 1'b0;
         if ((v.rq == 0 && ack0) || (v.rq == 1 && ack1)) begin
            got   = 1'b1;
            edges = k;
            e     = (v.rq == 1) ? err1 : err0;
            rdv   = (v.rq == 1) ? rdata1 : rdata0;
            break;
         end
      end
      drive(v.rq, 1'b0, 1'b0, '0, '0, 1'b0);
      check({tag, "_ack_seen"}, got, 1);
      check({tag, "_latency"}, edges, v.exp_edges);
      check({tag, "_err"}, e, v.exp_err);
      check({tag, "_rdata"}, rdv, v.exp_rdata);
      check({tag, "_nread"}, nrd, (v.rd && !v.wr) ? 1 : 0);
      check({tag, "_nwrite"}, nwr, (v.wr && !v.rd) ? 1 : 0);
      check({tag, "_mem_port"}, aok, 1);
      @(negedge clk);
      check({tag, "_ack_pulse"}, (v.rq == 1) ? ack1 : ack0, 0);
   endtask

   vec_t vecs[11];
   int   order[$];
   int   wcyc[$];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [ADDR_W-1:0] ba[3];
      logic [DATA_W-1:0] bd[3];
      int                c0, c1, n, exp_first;
      logic              sawack;
      vec_t              rb;

      //          rq rd    wr    addr    wdata  err   rdata  edges
      vecs[0]  = '{0, 1'b0, 1'b1, 5'd5,  8'hA5, 1'b0, 8'h00, 3};
      vecs[1]  = '{0, 1'b1, 1'b0, 5'd5,  8'h00, 1'b0, 8'hA5, 3};
      vecs[2]  = '{1, 1'b1, 1'b1, 5'd5,  8'h77, 1'b1, 8'h00, 2};
      vecs[3]  = '{1, 1'b0, 1'b1, 5'd0,  8'h3C, 1'b0, 8'h00, 3};
      vecs[4]  = '{1, 1'b1, 1'b0, 5'd0,  8'h00, 1'b0, 8'h3C, 3};
      vecs[5]  = '{1, 1'b0, 1'b0, 5'd5,  8'h00, 1'b1, 8'h3C, 2};
      vecs[6]  = '{0, 1'b0, 1'b1, 5'd31, 8'hFF, 1'b0, 8'hA5, 3};
      vecs[7]  = '{0, 1'b1, 1'b0, 5'd31, 8'h00, 1'b0, 8'hFF, 3};
      vecs[8]  = '{0, 1'b1, 1'b0, 5'd5,  8'h00, 1'b0, 8'hA5, 3};
      vecs[9]  = '{1, 1'b1, 1'b0, 5'd31, 8'h00, 1'b0, 8'hFF, 3};
      vecs[10] = '{0, 1'b0, 1'b0, 5'd9,  8'h00, 1'b1, 8'hA5, 2};

      // Reset state
      rst = 1'b1;
      drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
      drive(1, 1'b0, 1'b0, '0, '0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Table-driven single transactions
      for (int i = 0; i < 11; i++)
         do_txn(vecs[i], $sformatf("vec%0d", i));

      // Back-to-back writes with req1 held continuously
      ba[0] = 5'd0;  bd[0] = 8'h11;
      ba[1] = 5'd1;  bd[1] = 8'h22;
      ba[2] = 5'd31; bd[2] = 8'h33;
      n = 0;
      wcyc.delete();
      drive(1, 1'b0, 1'b1, ba[0], bd[0], 1'b1);
      for (int k = 0; k < 60 && n < 3; k++) begin
         @(negedge clk);
         if (mem_write) wcyc.push_back(k);
         if (ack1) begin
            n++;
            if (n < 3) drive(1, 1'b0, 1'b1, ba[n], bd[n], 1'b1);
            else       drive(1, 1'b0, 1'b0, '0, '0, 1'b0);
         end
      end
      @(negedge clk);
      check("b2b_acks", n, 3);
      check("b2b_writes", wcyc.size(), 3);
      check("b2b_gap1", (wcyc.size() == 3) ? wcyc[1] - wcyc[0] : -1, 4);
      check("b2b_gap2", (wcyc.size() == 3) ? wcyc[2] - wcyc[1] : -1, 4);
      check("b2b_mem0", mem[0], 8'h11);
      check("b2b_mem1", mem[1], 8'h22);
      check("b2b_mem31", mem[31], 8'h33);
      rb = '{0, 1'b1, 1'b0, 5'd31, 8'h00, 1'b0, 8'h33, 3};
      do_txn(rb, "readback31");
      rb = '{0, 1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 8'h11, 3};
      do_txn(rb, "readback0");

      // Reset during ACCESS: outputs clear at once, no ack afterwards
      drive(0, 1'b0, 1'b1, 5'd7, 8'h5A, 1'b1);
      @(posedge clk);
      @(negedge clk);
      check("rstmid_in_access", mem_write, 1);
      rst = 1'b1;
      #1;
      check_zero("rstmid");
      @(negedge clk);
      drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      sawack = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (ack0 || ack1 || mem_read || mem_write) sawack = 1'b1;
      end
      check("rstmid_no_activity", sawack, 0);

      // Contention: both hold read requests for two transactions each
      c0 = 0; c1 = 0;
      order.delete();
      drive(0, 1'b1, 1'b0, 5'd5,  '0, 1'b1);
      drive(1, 1'b1, 1'b0, 5'd31, '0, 1'b1);
      for (int k = 0; k < 60 && !(c0 == 2 && c1 == 2); k++) begin
         @(negedge clk);
         if (ack0) begin
            order.push_back(0);
            c0++;
            check($sformatf("cont_rdata0_%0d", c0), rdata0, 8'hA5);
            if (c0 == 2) drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
         end
         if (ack1) begin
            order.push_back(1);
            c1++;
            check($sformatf("cont_rdata1_%0d", c1), rdata1, 8'h33);
            if (c1 == 2) drive(1, 1'b0, 1'b0, '0, '0, 1'b0);
         end
      end
      @(negedge clk);
      check("cont_grants", order.size(), 4);
      for (int i = 0; i < 4; i++)
         check($sformatf("cont_order%0d", i), (i < order.size()) ? order[i] : 99, i % 2);

      // Pointer: after a lone grant to 0, a tie goes to 1 (round-robin)
      rb = '{0, 1'b1, 1'b0, 5'd5, 8'h00, 1'b0, 8'hA5, 3};
      do_txn(rb, "ptr_single");
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_first = 0;
`else
      exp_first = 1;
`endif
      c0 = 0; c1 = 0;
      order.delete();
      drive(0, 1'b1, 1'b0, 5'd1, '0, 1'b1);
      drive(1, 1'b1, 1'b0, 5'd0, '0, 1'b1);
      for (int k = 0; k < 40 && !(c0 == 1 && c1 == 1); k++) begin
         @(negedge clk);
         if (ack0) begin
            order.push_back(0); c0++;
            drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
         end
         if (ack1) begin
            order.push_back(1); c1++;
            drive(1, 1'b0, 1'b0, '0, '0, 1'b0);
         end
      end
      @(negedge clk);
      check("ptr_grants", order.size(), 2);
      check("ptr_first_winner", (order.size() > 0) ? order[0] : 99, exp_first);
      check("ptr_rdata0", rdata0, 8'h22);
      check("ptr_rdata1", rdata1, 8'h11);

      check("strobe_protocol", strobe_bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the synchronous 8x32 memory. It accepts read/write commands from two independent requesters and grants the single memory port to one at a time, round-robin. It drives the memory's read/write/addr/data_in strobes with correct one-cycle framing, then returns read data and a one-cycle acknowledge to the winner. It sits between the requester-side testbench/DMA agents and the memory interface.

## Interface
- ADDR_W, 5, memory address width (32 locations)
- DATA_W, 8, memory data width

- clk  input  1  memory clock; all state changes on posedge
- rst  input  1  reset, asynchronous, active-high
- req0 / req1  input  1  requester N command valid; held until ackN
- rd0 / rd1  input  1  requester N read command
- wr0 / wr1  input  1  requester N write command
- addr0 / addr1  input  ADDR_W  requester N address
- wdata0 / wdata1  input  DATA_W  requester N write data
- ack0 / ack1  output  1  one-cycle completion pulse to requester N
- err0 / err1  output  1  high with ackN when the command was illegal
- rdata0 / rdata1  output  DATA_W  read data for requester N, valid with ackN, held until next ack to N
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_addr  output  ADDR_W  memory address
- mem_data_in  output  DATA_W  memory write data
- mem_data_out  input  DATA_W  memory read data (registered by memory on read edge)

## Operation
- FSM states: IDLE, ACCESS, RESP. All outputs registered.
- Effective request: reqN_eff = reqN & ~ackN (masks the cycle the requester is still holding req after ack).
- IDLE: if any reqN_eff, pick winner; latch winner id, addr, wdata, rd, wr; go ACCESS. Else stay.
- Legal command: exactly one of rdN/wrN high. Illegal (both or neither): no memory strobe; go straight to RESP with err flagged.
- ACCESS (one cycle): mem_read=rd or mem_write=wr, mem_addr/mem_data_in from latch; go RESP.
- RESP: strobes low; for a read, capture mem_data_out into rdataN; pulse ackN (and errN if illegal) on the next cycle; go IDLE.
- Round-robin: a priority pointer names the preferred requester; after each grant it points to the non-winner. Pointer reset value: requester 0 preferred. Single requester always wins.
- Illegal commands consume a grant and advance the pointer.
- mem_read and mem_write are never high together; each is high for exactly one cycle per legal grant.

## Timing
- Reset values: ack0/1=0, err0/1=0, rdata0/1=0, mem_read=0, mem_write=0, mem_addr=0, mem_data_in=0, state=IDLE, pointer=0.
- Edge E0: req sampled in IDLE. After E0: strobes valid (ACCESS). E1: memory samples strobes; read data appears after E1. E2: rdataN captured, ackN rises. E3: ackN falls, state IDLE, req masked. E4: earliest next grant.
- Legal transaction: ack 2 cycles after acceptance edge; one transaction per 4 cycles max.
- Illegal transaction: ack+err 1 cycle after acceptance edge (IDLE→RESP).
- Simultaneous req0/req1 in IDLE: pointer decides; loser waits, granted at next IDLE edge it is unmasked.
- Requester dropping req before ack: transaction already latched completes; ack still issued.
- rst asserted mid-transaction: immediate return to reset values; in-flight transaction dropped, no ack; memory write already strobed may or may not have completed.

## Configuration
- MEM_ARB_FIXED_PRIO_EN defined: fixed priority, requester 0 always wins a simultaneous request; pointer logic removed.
- Not defined: round-robin as described.

## Test plan
- Reset: assert rst mid-ACCESS -> all outputs 0 immediately, no ack issued, FSM IDLE after release.
- Single write then read: req0 wr addr=5 data=8'hA5, then req0 rd addr=5 -> mem_write one cycle, ack0 2 cycles after accept; read ack0 with rdata0=8'hA5.
- Contention: req0 and req1 both read in same cycle, repeated 4 times -> grants alternate 0,1,0,1 (round-robin); with MEM_ARB_FIXED_PRIO_EN, requester 0 wins each simultaneous round while held.
- Illegal command: req1 with rd1=wr1=1 -> no mem strobe, ack1 and err1 high one cycle after accept, rdata1 unchanged.
- Back-to-back: req1 held continuously for 3 writes to addr 0,1,31 -> grants at 4-cycle spacing, memory holds written values, addr 31 wraps nothing.
- Strobe check (assertion): mem_read & mem_write never both 1; each strobe exactly one cycle wide.
